// File: rtl/afifo_read_checker.sv
// afifo_read_checker: read-side drain + sequence checker for the AFIFO stress test,
// and read-side responder of the cross-domain FIFO-reset toggle handshake.
// Optional feature macro: READCHK_STATS_EN (adds the 32-bit wordCount output).
module afifo_read_checker #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         r_ready,
    input  logic [W-1:0] r_data,
    output logic         r_trigger,
    input  logic         rstReq,
    output logic         rstReady,
    input  logic         rstDone,
    output logic         err,
    output logic [W-1:0] errExpected,
    output logic [W-1:0] errGot
`ifdef READCHK_STATS_EN
    ,
    output logic [31:0]  wordCount
`endif
);

    typedef enum logic [1:0] {
        ST_READ   = 2'd0,
        ST_SIGNAL = 2'd1,
        ST_WAIT   = 2'd2,
        ST_ERROR  = 2'd3
    } state_t;

    state_t       state;
    logic [W-1:0] last;
    logic         last_init;

    logic         req_s1, req_s2, req_prev;
    logic         done_s1, done_s2, done_prev;

    logic         req_pulse_c;
    logic         done_pulse_c;
    logic         accept_c;
    logic [W-1:0] last_inc_c;
    logic         seq_bad_c;

    // Two-flop synchronizers plus edge-detect registers for the async toggles
    always_ff @(posedge clk) begin
        if (rst) begin
            req_s1    <= 1'b0;
            req_s2    <= 1'b0;
            req_prev  <= 1'b0;
            done_s1   <= 1'b0;
            done_s2   <= 1'b0;
            done_prev <= 1'b0;
        end else begin
            req_s1    <= rstReq;
            req_s2    <= req_s1;
            req_prev  <= req_s2;
            done_s1   <= rstDone;
            done_s2   <= done_s1;
            done_prev <= done_s2;
        end
    end

    assign req_pulse_c  = req_s2 ^ req_prev;
    assign done_pulse_c = done_s2 ^ done_prev;
    assign accept_c     = r_trigger && r_ready;
    assign last_inc_c   = last + W'(1);
    assign seq_bad_c    = last_init && (r_data != last_inc_c);

    // Checker / handshake state machine with registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_READ;
            r_trigger   <= 1'b0;
            rstReady    <= 1'b0;
            err         <= 1'b0;
            errExpected <= '0;
            errGot      <= '0;
            last        <= '0;
            last_init   <= 1'b0;
        end else begin
            case (state)
                ST_READ: begin
                    r_trigger <= 1'b1;
                    if (accept_c && seq_bad_c) begin
                        err         <= 1'b1;
                        errExpected <= last_inc_c;
                        errGot      <= r_data;
                        r_trigger   <= 1'b0;
                        state       <= ST_ERROR;
                        // A request landing with the error is still answered so the writer never stalls
                        if (req_pulse_c) begin
                            rstReady <= ~rstReady;
                        end
                    end else begin
                        if (accept_c) begin
                            last      <= r_data;
                            last_init <= 1'b1;
                        end
                        if (req_pulse_c) begin
                            r_trigger <= 1'b0;
                            state     <= ST_SIGNAL;
                        end
                    end
                end
                ST_SIGNAL: begin
                    r_trigger <= 1'b0;
                    rstReady  <= ~rstReady;
                    state     <= ST_WAIT;
                end
                ST_WAIT: begin
                    r_trigger <= 1'b0;
                    if (req_pulse_c) begin
                        state <= ST_SIGNAL;
                    end else if (done_pulse_c) begin
                        last_init <= 1'b0;
                        r_trigger <= 1'b1;
                        state     <= ST_READ;
                    end
                end
                ST_ERROR: begin
                    r_trigger <= 1'b0;
                    if (req_pulse_c) begin
                        rstReady <= ~rstReady;
                    end
                end
                default: begin
                    r_trigger <= 1'b0;
                    state     <= ST_READ;
                end
            endcase
        end
    end

`ifdef READCHK_STATS_EN
    // Accepted-word counter; only rst clears it
    always_ff @(posedge clk) begin
        if (rst) begin
            wordCount <= '0;
        end else if (accept_c) begin
            wordCount <= wordCount + 32'd1;
        end
    end
`endif

endmodule
